// File: rtl/ray_pkg.sv
// ray_pkg: shared types and vector helpers for the ray generator and the
// intersection blocks.
//   rg_state_t : generator control states (IDLE, SETUP, RUN, DONE)
//   vec3_t     : three-component signed vector
//   vec3_add / vec3_sub / vec3_scale : wrapping vector arithmetic
// Components are carried at VEC_W bits. Each user keeps only the low bits
// it needs. Add, subtract and multiply wrap, so the low DIR_W bits of a
// VEC_W result equal the same computation done modulo 2^DIR_W
// (for DIR_W <= VEC_W).
package ray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } rg_state_t;

  localparam int VEC_W = 64;

  typedef logic signed [VEC_W-1:0] vcomp_t;

  typedef struct packed {
    vcomp_t x;
    vcomp_t y;
    vcomp_t z;
  } vec3_t;

  function automatic vec3_t vec3_add(input vec3_t a, input vec3_t b);
    vec3_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

  function automatic vec3_t vec3_sub(input vec3_t a, input vec3_t b);
    vec3_t r;
    r.x = a.x - b.x;
    r.y = a.y - b.y;
    r.z = a.z - b.z;
    return r;
  endfunction

  function automatic vec3_t vec3_scale(input vec3_t v, input vcomp_t s);
    vec3_t r;
    r.x = v.x * s;
    r.y = v.y * s;
    r.z = v.z * s;
    return r;
  endfunction

endpackage

// File: rtl/ray_lane_calc.sv
// ray_lane_calc: combinational direction for one output lane.
//   row_base_i : direction of column 0 of the current row
//   right_i    : camera right vector
//   x_i        : column of lane 0
//   width_i    : frame width
//   dir_*_o    : row_base + right*(x + LANE_IDX), low DIR_W bits; 0 when lane unused
//   valid_o    : x + LANE_IDX < width
module ray_lane_calc
  import ray_pkg::*;
#(
  parameter int DIM_W    = 13,
  parameter int DIR_W    = 32,
  parameter int LANE_IDX = 0
) (
  input  vec3_t             row_base_i,
  input  vec3_t             right_i,
  input  logic [DIM_W-1:0]  x_i,
  input  logic [DIM_W-1:0]  width_i,
  output logic [DIR_W-1:0]  dir_x_o,
  output logic [DIR_W-1:0]  dir_y_o,
  output logic [DIR_W-1:0]  dir_z_o,
  output logic              valid_o
);

  // Returns the three components packed x,y,z, truncated to DIR_W.
  function automatic logic [3*DIR_W-1:0] lane_dir(input vec3_t rb, input vec3_t r,
                                                  input vcomp_t col);
    vec3_t v;
    v = vec3_add(rb, vec3_scale(r, col));
    return {v.x[DIR_W-1:0], v.y[DIR_W-1:0], v.z[DIR_W-1:0]};
  endfunction

  // One extra bit so x + LANE_IDX cannot wrap near the top of the range.
  logic [DIM_W:0] col_s;

  assign col_s   = {1'b0, x_i} + (DIM_W+1)'(LANE_IDX);
  assign valid_o = (col_s < {1'b0, width_i});

  // col_s is unsigned, so the cast zero-extends.
  assign {dir_x_o, dir_y_o, dir_z_o} = valid_o ?
      lane_dir(row_base_i, right_i, vcomp_t'(col_s)) : {(3*DIR_W){1'b0}};

endmodule

// File: rtl/ray_generator_par.sv
// ray_generator_par: streams one primary-ray direction per pixel of a W x H
// frame, LANES adjacent pixels of one row per beat, on valid/ready.
//   clk, reset (sync, active-high), start (sampled in IDLE only)
//   cam_dir_*, cam_right_*, cam_up_* : signed camera vectors (latched at start)
//   image_width, image_height        : frame size (latched at start)
//   busy          : state != IDLE
//   out_valid/out_ready              : beat handshake
//   out_dir_{x,y,z}: lane k in bits [k*DIR_W +: DIR_W]
//   out_lane_mask : lane k holds a real pixel
//   out_px/out_py : coordinates of lane 0
//   out_last      : final beat of the frame
//   frame_done    : one-cycle pulse after the last beat is accepted
module ray_generator_par
  import ray_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int DIM_W   = 13,
  parameter int DIR_W   = 32,
  parameter int LANES   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [COORD_W-1:0]  cam_dir_x,
  input  logic signed [COORD_W-1:0]  cam_dir_y,
  input  logic signed [COORD_W-1:0]  cam_dir_z,
  input  logic signed [COORD_W-1:0]  cam_right_x,
  input  logic signed [COORD_W-1:0]  cam_right_y,
  input  logic signed [COORD_W-1:0]  cam_right_z,
  input  logic signed [COORD_W-1:0]  cam_up_x,
  input  logic signed [COORD_W-1:0]  cam_up_y,
  input  logic signed [COORD_W-1:0]  cam_up_z,
  input  logic [DIM_W-1:0]           image_width,
  input  logic [DIM_W-1:0]           image_height,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DIR_W-1:0]     out_dir_x,
  output logic [LANES*DIR_W-1:0]     out_dir_y,
  output logic [LANES*DIR_W-1:0]     out_dir_z,
  output logic [LANES-1:0]           out_lane_mask,
  output logic [DIM_W-1:0]           out_px,
  output logic [DIM_W-1:0]           out_py,
  output logic                       out_last,
  output logic                       frame_done
);

  localparam logic [DIM_W:0]   LANES_W = (DIM_W+1)'(LANES);
  localparam logic [DIM_W-1:0] LANES_D = DIM_W'(LANES);

  function automatic vec3_t sext3(input logic signed [COORD_W-1:0] a,
                                  input logic signed [COORD_W-1:0] b,
                                  input logic signed [COORD_W-1:0] c);
    vec3_t v;
    v.x = vcomp_t'(a);
    v.y = vcomp_t'(b);
    v.z = vcomp_t'(c);
    return v;
  endfunction

  rg_state_t         state_q, state_d;
  vec3_t             dir_q, right_q, up_q;
  vec3_t             row_base_q, row_base_d;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;

  logic              latch_s, load_beat_s, xfer_s, row_end_s, beat_last_s, dims_zero_s;
  logic signed [DIM_W:0] off_x_s, off_y_s;

  logic [LANES*DIR_W-1:0] lane_x_s, lane_y_s, lane_z_s;
  logic [LANES-1:0]       lane_mask_s;

  logic                   out_valid_q, out_last_q, frame_done_q, busy_q;
  logic [LANES*DIR_W-1:0] out_dir_x_q, out_dir_y_q, out_dir_z_q;
  logic [LANES-1:0]       out_lane_mask_q;
  logic [DIM_W-1:0]       out_px_q, out_py_q;

  assign dims_zero_s = (image_width == '0) || (image_height == '0);
  assign xfer_s      = out_valid_q & out_ready;
  // The current beat reaches the end of its row.
  assign row_end_s   = (({1'b0, x_q} + LANES_W) >= {1'b0, width_q});
  // Column offset of pixel 0 and row offset of row 0, floored halves.
  assign off_x_s     = -$signed({2'b00, width_q[DIM_W-1:1]});
  assign off_y_s     = $signed({2'b00, height_q[DIM_W-1:1]});
  // Last beat: final row and its mask covers column W-1.
  assign beat_last_s = (({1'b0, x_d} + LANES_W) >= {1'b0, width_q}) &&
                       (y_d == (height_q - DIM_W'(1)));

  // Next-state, counter and row-base control.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_base_d  = row_base_q;
    latch_s     = 1'b0;
    load_beat_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_s = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = dims_zero_s ? DONE : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        row_base_d  = vec3_add(dir_q, vec3_add(vec3_scale(right_q, vcomp_t'(off_x_s)),
                                               vec3_scale(up_q, vcomp_t'(off_y_s))));
        load_beat_s = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (xfer_s) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            load_beat_s = 1'b1;
            if (row_end_s) begin
              // Moving down one row lowers the up coefficient by one.
              x_d        = '0;
              y_d        = y_q + DIM_W'(1);
              row_base_d = vec3_sub(row_base_q, up_q);
            end else begin
              x_d = x_q + LANES_D;
            end
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lanes see the next counters so a new beat is registered without a bubble.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ray_lane_calc #(
      .DIM_W   (DIM_W),
      .DIR_W   (DIR_W),
      .LANE_IDX(k)
    ) u_lane (
      .row_base_i(row_base_d),
      .right_i   (right_q),
      .x_i       (x_d),
      .width_i   (width_q),
      .dir_x_o   (lane_x_s[k*DIR_W +: DIR_W]),
      .dir_y_o   (lane_y_s[k*DIR_W +: DIR_W]),
      .dir_z_o   (lane_z_s[k*DIR_W +: DIR_W]),
      .valid_o   (lane_mask_s[k])
    );
  end

  // State, pixel counters and row base.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
    end
  end

  // Per-frame camera and dimension latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q    <= '0;
      right_q  <= '0;
      up_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else if (latch_s) begin
      dir_q    <= sext3(cam_dir_x, cam_dir_y, cam_dir_z);
      right_q  <= sext3(cam_right_x, cam_right_y, cam_right_z);
      up_q     <= sext3(cam_up_x, cam_up_y, cam_up_z);
      width_q  <= image_width;
      height_q <= image_height;
    end
  end

  // Output beat register: loads on a new beat, clears after the last
  // transfer, otherwise holds (stable under backpressure).
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      out_dir_x_q     <= '0;
      out_dir_y_q     <= '0;
      out_dir_z_q     <= '0;
      out_lane_mask_q <= '0;
      out_px_q        <= '0;
      out_py_q        <= '0;
      out_last_q      <= 1'b0;
    end else if (load_beat_s) begin
      out_valid_q     <= 1'b1;
      out_dir_x_q     <= lane_x_s;
      out_dir_y_q     <= lane_y_s;
      out_dir_z_q     <= lane_z_s;
      out_lane_mask_q <= lane_mask_s;
      out_px_q        <= x_d;
      out_py_q        <= y_d;
      out_last_q      <= beat_last_s;
    end else if (xfer_s) begin
      out_valid_q     <= 1'b0;
      out_dir_x_q     <= '0;
      out_dir_y_q     <= '0;
      out_dir_z_q     <= '0;
      out_lane_mask_q <= '0;
      out_px_q        <= '0;
      out_py_q        <= '0;
      out_last_q      <= 1'b0;
    end
  end

  // Status outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign out_dir_x     = out_dir_x_q;
  assign out_dir_y     = out_dir_y_q;
  assign out_dir_z     = out_dir_z_q;
  assign out_lane_mask = out_lane_mask_q;
  assign out_px        = out_px_q;
  assign out_py        = out_py_q;
  assign out_last      = out_last_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_ray_generator_par.sv
// Directed bench for ray_generator_par: one LANES=1 and one LANES=4 instance.
module tb_ray_generator_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start1, start4, ready1, ready4;
  logic signed [10:0] cdx, cdy, cdz, crx, cry, crz, cux, cuy, cuz;
  logic [12:0] img_w, img_h;

  logic busy1, valid1, last1, fd1;
  logic [31:0] dx1, dy1, dz1;
  logic [0:0] mask1;
  logic [12:0] px1, py1;

  logic busy4, valid4, last4, fd4;
  logic [127:0] dx4, dy4, dz4;
  logic [3:0] mask4;
  logic [12:0] px4, py4;

  ray_generator_par #(.COORD_W(11), .DIM_W(13), .DIR_W(32), .LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .cam_dir_x(cdx), .cam_dir_y(cdy), .cam_dir_z(cdz),
    .cam_right_x(crx), .cam_right_y(cry), .cam_right_z(crz),
    .cam_up_x(cux), .cam_up_y(cuy), .cam_up_z(cuz),
    .image_width(img_w), .image_height(img_h),
    .busy(busy1), .out_valid(valid1), .out_ready(ready1),
    .out_dir_x(dx1), .out_dir_y(dy1), .out_dir_z(dz1),
    .out_lane_mask(mask1), .out_px(px1), .out_py(py1),
    .out_last(last1), .frame_done(fd1)
  );

  ray_generator_par #(.COORD_W(11), .DIM_W(13), .DIR_W(32), .LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .cam_dir_x(cdx), .cam_dir_y(cdy), .cam_dir_z(cdz),
    .cam_right_x(crx), .cam_right_y(cry), .cam_right_z(crz),
    .cam_up_x(cux), .cam_up_y(cuy), .cam_up_z(cuz),
    .image_width(img_w), .image_height(img_h),
    .busy(busy4), .out_valid(valid4), .out_ready(ready4),
    .out_dir_x(dx4), .out_dir_y(dy4), .out_dir_z(dz4),
    .out_lane_mask(mask4), .out_px(px4), .out_py(py4),
    .out_last(last4), .frame_done(fd4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference direction component: d + r*(px - W/2) + u*(H/2 - py).
  function automatic int exp_comp(input int d, input int r, input int u,
                                  input int px, input int py, input int w, input int h);
    return d + r * (px - w / 2) + u * (h / 2 - py);
  endfunction

  task automatic set_cam(input int dx, input int dy, input int dz,
                         input int rx, input int ry, input int rz,
                         input int ux, input int uy, input int uz);
    cdx = 11'(dx); cdy = 11'(dy); cdz = 11'(dz);
    crx = 11'(rx); cry = 11'(ry); crz = 11'(rz);
    cux = 11'(ux); cuy = 11'(uy); cuz = 11'(uz);
  endtask

  int m_dx, m_dy, m_dz, m_rx, m_ry, m_rz, m_ux, m_uy, m_uz;
  int cap_x[16], cap_y[16], cap_z[16], cap_px[16], cap_py[16];
  int ref_x[16], ref_y[16], ref_z[16], ref_px[16], ref_py[16];
  int e4x[4], e4z[4];

  // Runs one frame on the LANES=1 instance, checking every presented beat
  // against the reference model. stall_at/stall_len hold ready low,
  // glitch_at pulses start mid-frame, abort_at applies reset at that beat.
  task automatic run_frame1(input string tag, input int w, input int h,
                            input int stall_at, input int stall_len,
                            input int glitch_at, input int abort_at);
    int n, cyc, stall_used, first_cyc, last_cyc, total, epx, epy;
    bit aborted;
    total = w * h;
    m_dx = int'(cdx); m_dy = int'(cdy); m_dz = int'(cdz);
    m_rx = int'(crx); m_ry = int'(cry); m_rz = int'(crz);
    m_ux = int'(cux); m_uy = int'(cuy); m_uz = int'(cuz);
    img_w = 13'(w); img_h = 13'(h);
    ready1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    // Inputs changed after the start edge must not affect this frame.
    set_cam(-7, 3, 100, 9, -4, 2, 5, 5, -5);
    img_w = 13'd9; img_h = 13'd9;
    check_eq({tag, "_busy_start"}, longint'(busy1), 1);
    check_eq({tag, "_valid_start"}, longint'(valid1), 0);
    n = 0; cyc = 0; stall_used = 0; first_cyc = -1; last_cyc = -1; aborted = 1'b0;
    while (n < total && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && n == abort_at) begin
        aborted = 1'b1;
        break;
      end
      ready1 = !(n == stall_at && stall_used < stall_len);
      if (!ready1) stall_used++;
      start1 = (n == glitch_at);
      if (valid1) begin
        if (first_cyc < 0) first_cyc = cyc;
        epx = n % w;
        epy = n / w;
        check_eq({tag, "_px"}, longint'(px1), epx);
        check_eq({tag, "_py"}, longint'(py1), epy);
        check_eq({tag, "_dx"}, longint'($signed(dx1)), exp_comp(m_dx, m_rx, m_ux, epx, epy, w, h));
        check_eq({tag, "_dy"}, longint'($signed(dy1)), exp_comp(m_dy, m_ry, m_uy, epx, epy, w, h));
        check_eq({tag, "_dz"}, longint'($signed(dz1)), exp_comp(m_dz, m_rz, m_uz, epx, epy, w, h));
        check_eq({tag, "_mask"}, longint'(mask1), 1);
        check_eq({tag, "_last"}, longint'(last1), (n == total - 1) ? 1 : 0);
        if (ready1) begin
          if (n < 16) begin
            cap_x[n] = $signed(dx1); cap_y[n] = $signed(dy1); cap_z[n] = $signed(dz1);
            cap_px[n] = int'(px1); cap_py[n] = int'(py1);
          end
          last_cyc = cyc;
          n++;
        end
      end
    end
    start1 = 1'b0;
    ready1 = 1'b1;
    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq({tag, "_rst_valid"}, longint'(valid1), 0);
      check_eq({tag, "_rst_busy"}, longint'(busy1), 0);
      check_eq({tag, "_rst_done"}, longint'(fd1), 0);
      @(negedge clk);
      check_eq({tag, "_rst_done2"}, longint'(fd1), 0);
      check_eq({tag, "_rst_valid2"}, longint'(valid1), 0);
    end else begin
      check_eq({tag, "_beats"}, n, total);
      check_eq({tag, "_first_valid_cyc"}, first_cyc, 1);
      check_eq({tag, "_cycles"}, last_cyc - first_cyc + 1, total + stall_len);
      @(negedge clk);
      check_eq({tag, "_done"}, longint'(fd1), 1);
      check_eq({tag, "_valid_after"}, longint'(valid1), 0);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, longint'(fd1), 0);
      check_eq({tag, "_idle"}, longint'(busy1), 0);
    end
  endtask

  task automatic check_beat4(input string tag, input int mask, input int px, input int last);
    check_eq({tag, "_valid"}, longint'(valid4), 1);
    check_eq({tag, "_mask"}, longint'(mask4), mask);
    check_eq({tag, "_px"}, longint'(px4), px);
    check_eq({tag, "_py"}, longint'(py4), 0);
    check_eq({tag, "_last"}, longint'(last4), last);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_x%0d", tag, k), longint'($signed(dx4[k*32 +: 32])), e4x[k]);
      check_eq($sformatf("%s_y%0d", tag, k), longint'($signed(dy4[k*32 +: 32])), 0);
      check_eq($sformatf("%s_z%0d", tag, k), longint'($signed(dz4[k*32 +: 32])), e4z[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen_valid;
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; ready1 = 1'b1; ready4 = 1'b1;
    set_cam(0, 0, 5, 1, 0, 0, 0, 1, 0);
    img_w = 13'd4; img_h = 13'd2;
    repeat (3) @(negedge clk);
    check_eq("reset_valid1", longint'(valid1), 0);
    check_eq("reset_busy1", longint'(busy1), 0);
    check_eq("reset_done1", longint'(fd1), 0);
    check_eq("reset_dx1", longint'(dx1), 0);
    check_eq("reset_valid4", longint'(valid4), 0);
    check_eq("reset_mask4", longint'(mask4), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4x2 frame, ready tied high.
    run_frame1("t1", 4, 2, -1, 0, -1, -1);
    check_eq("t1_first_x", cap_x[0], -2);
    check_eq("t1_first_y", cap_y[0], 1);
    check_eq("t1_first_z", cap_z[0], 5);
    check_eq("t1_last_x", cap_x[7], 1);
    check_eq("t1_last_y", cap_y[7], 0);
    check_eq("t1_last_z", cap_z[7], 5);
    check_eq("t1_last_px", cap_px[7], 3);
    check_eq("t1_last_py", cap_py[7], 1);
    for (int i = 0; i < 8; i++) begin
      ref_x[i] = cap_x[i]; ref_y[i] = cap_y[i]; ref_z[i] = cap_z[i];
      ref_px[i] = cap_px[i]; ref_py[i] = cap_py[i];
    end

    // Same frame with a 5-cycle stall and a start pulse mid-frame.
    set_cam(0, 0, 5, 1, 0, 0, 0, 1, 0);
    run_frame1("t2", 4, 2, 3, 5, 5, -1);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t2_seq_x%0d", i), cap_x[i], ref_x[i]);
      check_eq($sformatf("t2_seq_y%0d", i), cap_y[i], ref_y[i]);
      check_eq($sformatf("t2_seq_px%0d", i), cap_px[i], ref_px[i]);
      check_eq($sformatf("t2_seq_py%0d", i), cap_py[i], ref_py[i]);
    end

    // Zero width: no beats, one busy cycle, frame_done pulse.
    img_w = 13'd0; img_h = 13'd7;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check_eq("t3_busy", longint'(busy1), 1);
    check_eq("t3_valid", longint'(valid1), 0);
    check_eq("t3_done", longint'(fd1), 1);
    seen_valid = 0;
    @(negedge clk);
    check_eq("t3_busy_end", longint'(busy1), 0);
    check_eq("t3_done_pulse", longint'(fd1), 0);
    repeat (3) begin
      if (valid1) seen_valid++;
      @(negedge clk);
    end
    check_eq("t3_no_valid", seen_valid, 0);

    // Negative camera vectors.
    set_cam(0, 0, 0, -1, 0, 0, 0, 0, -2);
    run_frame1("t4", 2, 2, -1, 0, -1, -1);
    check_eq("t4_p00_x", cap_x[0], 1);
    check_eq("t4_p00_y", cap_y[0], 0);
    check_eq("t4_p00_z", cap_z[0], -2);
    check_eq("t4_p11_x", cap_x[3], 0);
    check_eq("t4_p11_y", cap_y[3], 0);
    check_eq("t4_p11_z", cap_z[3], 0);

    // Reset at beat 3 (start pulse at beat 1 ignored), then a fresh frame.
    set_cam(0, 0, 5, 1, 0, 0, 0, 1, 0);
    run_frame1("t5a", 4, 2, -1, 0, 1, 3);
    set_cam(0, 0, 5, 1, 0, 0, 0, 1, 0);
    run_frame1("t5b", 4, 2, -1, 0, -1, -1);
    check_eq("t5b_first_px", cap_px[0], 0);
    check_eq("t5b_first_x", cap_x[0], -2);

    // LANES=4, W=6, H=1.
    set_cam(0, 0, 5, 1, 0, 0, 0, 1, 0);
    img_w = 13'd6; img_h = 13'd1;
    ready4 = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check_eq("t6_valid_start", longint'(valid4), 0);
    check_eq("t6_busy_start", longint'(busy4), 1);
    @(negedge clk);
    e4x[0] = -3; e4x[1] = -2; e4x[2] = -1; e4x[3] = 0;
    e4z[0] = 5;  e4z[1] = 5;  e4z[2] = 5;  e4z[3] = 5;
    check_beat4("t6_b1", 15, 0, 0);
    @(negedge clk);
    e4x[0] = 1; e4x[1] = 2; e4x[2] = 0; e4x[3] = 0;
    e4z[0] = 5; e4z[1] = 5; e4z[2] = 0; e4z[3] = 0;
    check_beat4("t6_b2", 3, 4, 1);
    @(negedge clk);
    check_eq("t6_done", longint'(fd4), 1);
    check_eq("t6_valid_after", longint'(valid4), 0);
    @(negedge clk);
    check_eq("t6_done_pulse", longint'(fd4), 0);
    check_eq("t6_idle", longint'(busy4), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
